craps_game_ctrl: RTL and testbench
==================================

Name: craps_game_ctrl

Overview:
- Sequencing controller for the two-dice game.
- Debounces the roll button and runs two free-running dice counters.
- Latches the dice on button release and applies craps rules (come-out roll, then point phase).
- Drives the two 7-segment displays and the win/lose LEDs; sits between the board button/LEDs and the top-level game wrapper.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a new roll level; range 1..65535.
- SEG_ACTIVE_LOW, 1: 1 = segment lit by driving 0; 0 = lit by driving 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- roll  in  1  raw roll button, asynchronous, 1 = pressed
- die1  out  3  latched die 1 value, 0 = none yet, else 1..6
- die2  out  3  latched die 2 value, 0 = none yet, else 1..6
- disp1  out  7  die 1 segments, order {g,f,e,d,c,b,a}
- disp2  out  7  die 2 segments, same order
- point  out  4  established point value (4,5,6,8,9,10), 0 when none
- point_valid  out  1  high while in point phase
- win  out  1  green LED, held until next game starts
- lose  out  1  red LED, held until next game starts

Behaviour:
- Reset (any cycle, overrides all activity):
  - die1 = die2 = 0, point = 0, point_valid = 0, win = lose = 0.
  - Both displays blank; state = COME_OUT.
  - Dice counters = 1; debounce counter = 0; roll_db = 0.
- Input conditioning:
  - roll passes through a 2-FF synchronizer.
  - roll_db toggles to the synchronized level after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreeing sample clears the counter.
  - Press = roll_db 0->1; release = roll_db 1->0; one-cycle pulses.
- Dice counters:
  - c1 advances 1..6 every cycle, wrapping 6->1.
  - c2 advances 1..6 only in cycles where c1 wraps 6->1.
  - Counters free-run from reset regardless of state, giving a 36-cycle period.
  - Sequence is deterministic: after reset deassertion, cycle k gives c1 = (k mod 6)+1 and c2 = ((k div 6) mod 6)+1.
- Displays:
  - While roll_db = 1, disp1/disp2 show live c1/c2 as rolling animation.
  - Otherwise they show latched die1/die2; value 0 shows blank (all segments off).
  - Active-high codes {g..a}: 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101. Inverted when SEG_ACTIVE_LOW = 1.
- Release evaluation:
  - On the release edge, die1 <= c1 and die2 <= c2; the state update uses sum = c1 + c2 (4-bit, 2..12) from that same cycle.
  - All outputs are registered and visible the cycle after the release pulse.
- State machine:
  - COME_OUT, press: no effect beyond the animation.
  - COME_OUT, release:
    - sum 7 or 11 -> GAME_WIN, win = 1.
    - sum 2, 3 or 12 -> GAME_LOSE, lose = 1.
    - otherwise -> POINT, point = sum, point_valid = 1.
  - POINT, release:
    - sum == point -> GAME_WIN, win = 1, point_valid = 0; point keeps its value.
    - sum == 7 -> GAME_LOSE, lose = 1, point_valid = 0.
    - otherwise stay in POINT.
  - GAME_WIN / GAME_LOSE, press:
    - New game: win = lose = 0, point = 0, point_valid = 0.
    - Go to COME_OUT with roll held, so the coming release is evaluated as a come-out roll.
    - Latched dice remain until that release.
  - GAME_WIN / GAME_LOSE, release without a prior press in the terminal state: ignored.
- Invariants: win and lose are never both 1; point_valid = 1 implies point is in {4,5,6,8,9,10}.
- Reset mid-roll (button held): the controller restarts in COME_OUT with roll_db = 0. The still-held button must re-debounce as a fresh press.

Optional Feature:
- Macro: CRAPS_ROLL_COUNT_EN.
- With the macro defined:
  - Adds output roll_count, 8 bits: number of evaluated releases in the current game.
  - Incremented with each evaluation, saturating at 255.
  - Cleared by reset and by the new-game press.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES = 4, SEG_ACTIVE_LOW = 0; release timing is computed from the deterministic counter sequence.
- Reset check: assert reset 3 cycles -> die1/die2 = 0, disp1 = disp2 = 0000000, win = lose = point_valid = 0, point = 0.
- Come-out win: release captures c1 = 3, c2 = 4 -> next cycle die1 = 3, die2 = 4, disp1 = 1001111, disp2 = 1100110, win = 1, lose = 0.
- Come-out loss: capture 1,1 -> lose = 1, win = 0. Then press -> lose clears and state returns to COME_OUT.
- Point then win / point then loss:
  - Capture 2,4 -> point = 6, point_valid = 1.
  - Then capture 5,3 -> no change.
  - Then capture 1,5 -> win = 1.
  - Repeat the game with a second roll of 3,4 -> lose = 1, point_valid = 0.
- Bounce rejection: roll pulses of 1-3 cycles -> roll_db never rises, displays stay static, state unchanged. A 10-cycle press is accepted.
- Reset mid-point: reset while in POINT with point = 8 -> every output returns to its reset value next cycle. With CRAPS_ROLL_COUNT_EN, roll_count = 0.

Source files
------------

// File: rtl/craps_game_ctrl_if.sv
// Board-facing signals of the craps controller: roll button in, dice, segments and LEDs out.
// roll_count exists only when CRAPS_ROLL_COUNT_EN is defined.
interface craps_game_ctrl_if;
  logic       roll;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [6:0] disp1;
  logic [6:0] disp2;
  logic [3:0] point;
  logic       point_valid;
  logic       win;
  logic       lose;
`ifdef CRAPS_ROLL_COUNT_EN
  logic [7:0] roll_count;

  modport master (
    input  roll,
    output die1, die2, disp1, disp2, point, point_valid, win, lose, roll_count
  );
  modport slave (
    output roll,
    input  die1, die2, disp1, disp2, point, point_valid, win, lose, roll_count
  );
`else
  modport master (
    input  roll,
    output die1, die2, disp1, disp2, point, point_valid, win, lose
  );
  modport slave (
    output roll,
    input  die1, die2, disp1, disp2, point, point_valid, win, lose
  );
`endif
endinterface

// File: rtl/craps_game_ctrl.sv
// Craps sequencer: debounced roll button, free-running dice, come-out/point rules; results one cycle after release.
// Optional CRAPS_ROLL_COUNT_EN adds a saturating per-game count of evaluated releases.
module craps_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  craps_game_ctrl_if.master game_if
);

  typedef enum logic [1:0] {COME_OUT, POINT, GAME_WIN, GAME_LOSE} state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state_q;
  logic        roll_s1_q, roll_s2_q;
  logic        roll_db_q, roll_db_d, roll_db_prev_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic [2:0]  c1_q, c1_d, c2_q, c2_d;
  logic [2:0]  die1_q, die2_q;
  logic [3:0]  point_q;
  logic        point_valid_q, win_q, lose_q;
  logic        press, release_evt;
  logic [3:0]  sum;

  function automatic logic [6:0] seg_enc(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1011011;
      3'd3:    s = 7'b1001111;
      3'd4:    s = 7'b1100110;
      3'd5:    s = 7'b1101101;
      3'd6:    s = 7'b1111101;
      default: s = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  // Any sample agreeing with roll_db restarts the stability count.
  always_comb begin
    roll_db_d = roll_db_q;
    db_cnt_d  = '0;
    if (roll_s2_q != roll_db_q) begin
      if (db_cnt_q == DB_LAST) roll_db_d = roll_s2_q;
      else                     db_cnt_d  = db_cnt_q + 16'd1;
    end
    c1_d = (c1_q == 3'd6) ? 3'd1 : c1_q + 3'd1;
    c2_d = c2_q;
    if (c1_q == 3'd6) c2_d = (c2_q == 3'd6) ? 3'd1 : c2_q + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      roll_s1_q      <= 1'b0;
      roll_s2_q      <= 1'b0;
      roll_db_q      <= 1'b0;
      roll_db_prev_q <= 1'b0;
      db_cnt_q       <= '0;
      c1_q           <= 3'd1;
      c2_q           <= 3'd1;
    end else begin
      roll_s1_q      <= game_if.roll;
      roll_s2_q      <= roll_s1_q;
      roll_db_q      <= roll_db_d;
      roll_db_prev_q <= roll_db_q;
      db_cnt_q       <= db_cnt_d;
      c1_q           <= c1_d;
      c2_q           <= c2_d;
    end
  end

  assign press       = roll_db_q & ~roll_db_prev_q;
  assign release_evt = ~roll_db_q & roll_db_prev_q;
  assign sum         = {1'b0, c1_q} + {1'b0, c2_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= COME_OUT;
      die1_q        <= '0;
      die2_q        <= '0;
      point_q       <= '0;
      point_valid_q <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      case (state_q)
        COME_OUT: if (release_evt) begin
          die1_q <= c1_q;
          die2_q <= c2_q;
          if (sum == 4'd7 || sum == 4'd11) begin
            state_q <= GAME_WIN;
            win_q   <= 1'b1;
          end else if (sum == 4'd2 || sum == 4'd3 || sum == 4'd12) begin
            state_q <= GAME_LOSE;
            lose_q  <= 1'b1;
          end else begin
            state_q       <= POINT;
            point_q       <= sum;
            point_valid_q <= 1'b1;
          end
        end
        POINT: if (release_evt) begin
          die1_q <= c1_q;
          die2_q <= c2_q;
          if (sum == point_q) begin
            state_q       <= GAME_WIN;
            win_q         <= 1'b1;
            point_valid_q <= 1'b0;
          end else if (sum == 4'd7) begin
            state_q       <= GAME_LOSE;
            lose_q        <= 1'b1;
            point_valid_q <= 1'b0;
          end
        end
        GAME_WIN, GAME_LOSE: if (press) begin
          // Button is still down: the upcoming release is the new come-out roll.
          state_q       <= COME_OUT;
          win_q         <= 1'b0;
          lose_q        <= 1'b0;
          point_q       <= '0;
          point_valid_q <= 1'b0;
        end
        default: state_q <= COME_OUT;
      endcase
    end
  end

`ifdef CRAPS_ROLL_COUNT_EN
  logic [7:0] roll_count_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      roll_count_q <= '0;
    end else if (press && (state_q == GAME_WIN || state_q == GAME_LOSE)) begin
      roll_count_q <= '0;
    end else if (release_evt && (state_q == COME_OUT || state_q == POINT)) begin
      if (roll_count_q != 8'hff) roll_count_q <= roll_count_q + 8'd1;
    end
  end
  assign game_if.roll_count = roll_count_q;
`endif

  assign game_if.die1        = die1_q;
  assign game_if.die2        = die2_q;
  assign game_if.disp1       = seg_enc(roll_db_q ? c1_q : die1_q);
  assign game_if.disp2       = seg_enc(roll_db_q ? c2_q : die2_q);
  assign game_if.point       = point_q;
  assign game_if.point_valid = point_valid_q;
  assign game_if.win         = win_q;
  assign game_if.lose        = lose_q;

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Bench for craps_game_ctrl: table of rolls scored through an expected-result queue, plus reset/bounce sequences.
module tb_craps_game_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  craps_game_ctrl_if gif();

  craps_game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .game_if(gif)
  );

  always #5 clock = ~clock;

  // Cycle index since reset release; dice are c1 = cyc%6+1, c2 = (cyc/6)%6+1.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  typedef struct {
    int a; int b; int pt; int pv; int w; int l;
  } vec_t;

  typedef struct {
    int due; int d1; int d2; int pt; int pv; int w; int l;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];

  function automatic int seg(input int v);
    case (v)
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due != cyc) begin
        chk("sb_due", cyc, e.due);
      end else begin
        chk("die1",        int'(gif.die1),        e.d1);
        chk("die2",        int'(gif.die2),        e.d2);
        chk("disp1",       int'(gif.disp1),       seg(e.d1));
        chk("disp2",       int'(gif.disp2),       seg(e.d2));
        chk("point",       int'(gif.point),       e.pt);
        chk("point_valid", int'(gif.point_valid), e.pv);
        chk("win",         int'(gif.win),         e.w);
        chk("lose",        int'(gif.lose),        e.l);
        chk("win_lose_excl", int'(gif.win & gif.lose), 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    sb_check();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_die1"},  int'(gif.die1),        0);
    chk({tag, "_die2"},  int'(gif.die2),        0);
    chk({tag, "_disp1"}, int'(gif.disp1),       0);
    chk({tag, "_disp2"}, int'(gif.disp2),       0);
    chk({tag, "_point"}, int'(gif.point),       0);
    chk({tag, "_pv"},    int'(gif.point_valid), 0);
    chk({tag, "_win"},   int'(gif.win),         0);
    chk({tag, "_lose"},  int'(gif.lose),        0);
`ifdef CRAPS_ROLL_COUNT_EN
    chk({tag, "_roll_count"}, int'(gif.roll_count), 0);
`endif
  endtask

  task automatic chk_anim(input string tag);
    chk({tag, "_disp1"}, int'(gif.disp1), seg(cyc % 6 + 1));
    chk({tag, "_disp2"}, int'(gif.disp2), seg((cyc / 6) % 6 + 1));
  endtask

  // Button is held; drop it so the release pulse lands on dice (a,b), 6 cycles after the drive.
  task automatic release_at(input int a, input int b, input int pt, input int pv,
                            input int w, input int l);
    exp_t e;
    int   n;
    n = 0;
    while (((cyc + 6) % 36) != ((b - 1) * 6 + (a - 1)) && n < 40) begin
      tick();
      n++;
    end
    chk("release_slot_found", int'(n < 40), 1);
    gif.roll = 1'b0;
    e = '{due: cyc + 7, d1: a, d2: b, pt: pt, pv: pv, w: w, l: l};
    sb_q.push_back(e);
    repeat (8) tick();
  endtask

  initial begin
    vecs[0] = '{a: 3, b: 4, pt: 0, pv: 0, w: 1, l: 0};
    vecs[1] = '{a: 1, b: 1, pt: 0, pv: 0, w: 0, l: 1};
    vecs[2] = '{a: 2, b: 4, pt: 6, pv: 1, w: 0, l: 0};
    vecs[3] = '{a: 5, b: 3, pt: 6, pv: 1, w: 0, l: 0};
    vecs[4] = '{a: 1, b: 5, pt: 6, pv: 0, w: 1, l: 0};
    vecs[5] = '{a: 2, b: 4, pt: 6, pv: 1, w: 0, l: 0};
    vecs[6] = '{a: 3, b: 4, pt: 6, pv: 0, w: 0, l: 1};
    vecs[7] = '{a: 6, b: 5, pt: 0, pv: 0, w: 1, l: 0};
    vecs[8] = '{a: 6, b: 6, pt: 0, pv: 0, w: 0, l: 1};

    gif.roll = 1'b0;
    reset    = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      gif.roll = 1'b1;
      repeat (8) tick();
      release_at(vecs[i].a, vecs[i].b, vecs[i].pt, vecs[i].pv, vecs[i].w, vecs[i].l);
    end

    // New-game press from a loss clears the LEDs while the dice animate.
    gif.roll = 1'b1;
    repeat (8) tick();
    chk("newgame_lose", int'(gif.lose),        0);
    chk("newgame_win",  int'(gif.win),         0);
    chk("newgame_pv",   int'(gif.point_valid), 0);
    chk("newgame_pt",   int'(gif.point),       0);
    chk_anim("newgame_anim");
    release_at(4, 4, 8, 1, 0, 0);

    for (int w = 1; w <= 3; w++) begin
      gif.roll = 1'b1;
      repeat (w) tick();
      gif.roll = 1'b0;
      repeat (10) begin
        tick();
        chk($sformatf("bounce%0d_disp1", w), int'(gif.disp1), seg(4));
        chk($sformatf("bounce%0d_disp2", w), int'(gif.disp2), seg(4));
      end
      chk($sformatf("bounce%0d_pv", w), int'(gif.point_valid), 1);
      chk($sformatf("bounce%0d_pt", w), int'(gif.point),       8);
    end

    gif.roll = 1'b1;
    repeat (10) tick();
    chk_anim("long_press_anim");
    release_at(6, 3, 8, 1, 0, 0);

    reset = 1'b1;
    tick();
    chk_reset_vals("reset_mid_point");
    reset = 1'b0;

    gif.roll = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("reset_mid_roll");
    reset = 1'b0;
    repeat (5) tick();
    chk("held_pre_db_disp1", int'(gif.disp1), 0);
    chk("held_pre_db_disp2", int'(gif.disp2), 0);
    tick();
    chk_anim("held_redebounce");
    release_at(3, 4, 0, 0, 1, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
